ahb_burst_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one AHB_Master among NUM_REQ requesters.

---
 rtl/ahb_burst_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_arbiter
// Desc     : Round-robin arbiter sharing one AHB master between NUM_REQ
//            requesters; sequences NONSEQ/SEQ INCR bursts on the P* bus.
// Revision : 1.0  initial release
// ============================================================================
module ahb_burst_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [32*NUM_REQ-1:0]    REQ_ADDR,
    input  logic [NUM_REQ-1:0]       REQ_WRITE,
    input  logic [3*NUM_REQ-1:0]     REQ_SIZE,
    input  logic [LEN_W*NUM_REQ-1:0] REQ_LEN,
    input  logic [32*NUM_REQ-1:0]    REQ_WDATA,
    input  logic                     HREADY,
    input  logic                     HRESP,
    output logic [NUM_REQ-1:0]       REQ_GRANT,
    output logic [NUM_REQ-1:0]       REQ_BEAT,
    output logic [NUM_REQ-1:0]       REQ_DONE,
    output logic [NUM_REQ-1:0]       REQ_ERR,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic [2:0]               PSIZE,
    output logic [1:0]               PTRANS,
    output logic [2:0]               PBURST,
    output logic                     BUSY
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NONSEQ = 2'd1,
        ST_SEQ    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OW-1:0]      owner, owner_nxt;
    logic [OW-1:0]      rr_ptr, rr_nxt;
    logic [LEN_W-1:0]   remain, remain_nxt;
    logic [31:0]        paddr_nxt, pwdata_nxt;
    logic               pwrite_nxt, busy_nxt;
    logic [2:0]         psize_nxt, pburst_nxt;
    logic [1:0]         ptrans_nxt;
    logic [NUM_REQ-1:0] grant_nxt, beat_nxt, done_nxt, err_nxt;

    logic [31:0]        addr_a  [NUM_REQ];
    logic [31:0]        wdata_a [NUM_REQ];
    logic [2:0]         size_a  [NUM_REQ];
    logic [LEN_W-1:0]   len_a   [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_a[gi]  = REQ_ADDR[32*gi +: 32];
            assign wdata_a[gi] = REQ_WDATA[32*gi +: 32];
            assign size_a[gi]  = (REQ_SIZE[3*gi +: 3] > 3'd2) ? 3'd2 : REQ_SIZE[3*gi +: 3];
            assign len_a[gi]   = REQ_LEN[LEN_W*gi +: LEN_W];
        end
    endgenerate

    // First valid requester at or after the round-robin pointer, wrapping.
    logic          win_found;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = OW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && REQ_VALID[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_nxt     = rr_ptr;
        remain_nxt = remain;
        paddr_nxt  = PADDR;
        pwdata_nxt = PWDATA;
        pwrite_nxt = PWRITE;
        psize_nxt  = PSIZE;
        ptrans_nxt = PTRANS;
        pburst_nxt = PBURST;
        grant_nxt  = REQ_GRANT;
        busy_nxt   = BUSY;
        beat_nxt   = '0;
        done_nxt   = '0;
        err_nxt    = '0;

        case (state)
            ST_IDLE: begin
                paddr_nxt  = '0;
                pwdata_nxt = '0;
                pwrite_nxt = 1'b0;
                psize_nxt  = '0;
                ptrans_nxt = TRANS_IDLE;
                pburst_nxt = BURST_SINGLE;
                grant_nxt  = '0;
                busy_nxt   = 1'b0;
                if (win_found) begin
                    state_nxt          = ST_NONSEQ;
                    owner_nxt          = win_idx;
                    paddr_nxt          = addr_a[win_idx];
                    pwdata_nxt         = wdata_a[win_idx];
                    pwrite_nxt         = REQ_WRITE[win_idx];
                    psize_nxt          = size_a[win_idx];
                    ptrans_nxt         = TRANS_NONSEQ;
                    // A zero length is run as a single beat.
                    remain_nxt         = (len_a[win_idx] == '0) ? '0 : len_a[win_idx] - 1'b1;
                    pburst_nxt         = (len_a[win_idx] > LEN_W'(1)) ? BURST_INCR : BURST_SINGLE;
                    grant_nxt[win_idx] = 1'b1;
                    busy_nxt           = 1'b1;
                end
            end
            ST_NONSEQ, ST_SEQ: begin
                pwdata_nxt = wdata_a[owner];
                if (HRESP || (HREADY && remain == '0)) begin
                    if (HRESP) begin
                        err_nxt[owner] = 1'b1;
                    end else begin
                        beat_nxt[owner] = 1'b1;
                        done_nxt[owner] = 1'b1;
                    end
                    state_nxt  = ST_IDLE;
                    rr_nxt     = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    paddr_nxt  = '0;
                    pwdata_nxt = '0;
                    pwrite_nxt = 1'b0;
                    psize_nxt  = '0;
                    ptrans_nxt = TRANS_IDLE;
                    pburst_nxt = BURST_SINGLE;
                    grant_nxt  = '0;
                    busy_nxt   = 1'b0;
                end else if (HREADY) begin
                    beat_nxt[owner] = 1'b1;
                    state_nxt       = ST_SEQ;
                    remain_nxt      = remain - 1'b1;
                    paddr_nxt       = PADDR + (32'd1 << PSIZE);
                    ptrans_nxt      = TRANS_SEQ;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                ptrans_nxt = TRANS_IDLE;
                grant_nxt  = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            remain    <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSIZE     <= '0;
            PTRANS    <= TRANS_IDLE;
            PBURST    <= BURST_SINGLE;
            REQ_GRANT <= '0;
            REQ_BEAT  <= '0;
            REQ_DONE  <= '0;
            REQ_ERR   <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            remain    <= remain_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            PWRITE    <= pwrite_nxt;
            PSIZE     <= psize_nxt;
            PTRANS    <= ptrans_nxt;
            PBURST    <= pburst_nxt;
            REQ_GRANT <= grant_nxt;
            REQ_BEAT  <= beat_nxt;
            REQ_DONE  <= done_nxt;
            REQ_ERR   <= err_nxt;
            BUSY      <= busy_nxt;
        end
    end

endmodule
`default_nettype wire
